// File: rtl/regfile_pkg.sv
// Shared constants and the write-request bundle for the regfile writeback path.
// XZR (register 31) reads as zero, so writes to it are accepted and dropped.
package regfile_pkg;
   localparam int           DATA_W   = 64;
   localparam int           NUM_REGS = 32;
   localparam logic [4:0]   REG_XZR  = 5'd31;

   typedef struct packed {
      logic [4:0]        addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant, combinational from valid/stall and the last-granted flop.
// Latency: grant is same-cycle; backpressure: stall or reset low suppresses every grant.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_stall,
   input  logic [1:0] i_valid,
   output logic [1:0] o_grant
);
   logic       r_last;
   logic [1:0] w_grant;

   always_comb begin
      w_grant = 2'b00;
      if (reset && !i_stall) begin
         case (i_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
         endcase
      end
   end

   // Reset value 1 lets requester 0 win the first contested cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_last <= 1'b1;
      else if (w_grant[1])
         r_last <= 1'b1;
      else if (w_grant[0])
         r_last <= 1'b0;
   end

   assign o_grant = w_grant;
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates two writeback requesters onto the single regfile write port, with a bypass.
// Latency: grant at edge k drives we3 in cycle k+1; backpressure only via stall (port drains every cycle).
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int N = DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         req0_valid,
   input  logic [4:0]   req0_addr,
   input  logic [N-1:0] req0_data,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [4:0]   req1_addr,
   input  logic [N-1:0] req1_data,
   output logic         req1_ready,
   input  logic [4:0]   ra1,
   input  logic [4:0]   ra2,
   output logic         byp1,
   output logic         byp2,
   output logic [N-1:0] byp_data,
   output logic         we3,
   output logic [4:0]   wa3,
   output logic [N-1:0] wd3
);
   logic [1:0]  w_grant;
   wr_req_t     w_req0;
   wr_req_t     w_req1;
   wr_req_t     w_sel;
   logic        r_we3;
   logic [4:0]  r_wa3;
   logic [N-1:0] r_wd3;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_stall (stall),
      .i_valid ({req1_valid, req0_valid}),
      .o_grant (w_grant)
   );

   assign req0_ready = w_grant[0];
   assign req1_ready = w_grant[1];

   assign w_req0 = '{addr: req0_addr, data: req0_data};
   assign w_req1 = '{addr: req1_addr, data: req1_data};
   assign w_sel  = w_grant[1] ? w_req1 : w_req0;

   // wa3/wd3 hold when idle; only we3 is cleared, so a dropped XZR write still lands in wa3.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we3 <= 1'b0;
         r_wa3 <= 5'd0;
         r_wd3 <= '0;
      end else if (|w_grant) begin
         r_we3 <= (w_sel.addr != REG_XZR);
         r_wa3 <= w_sel.addr;
         r_wd3 <= w_sel.data;
      end else begin
         r_we3 <= 1'b0;
      end
   end

   assign we3      = r_we3;
   assign wa3      = r_wa3;
   assign wd3      = r_wd3;
   assign byp_data = r_wd3;
   assign byp1     = r_we3 && (r_wa3 == ra1) && (ra1 != REG_XZR);
   assign byp2     = r_we3 && (r_wa3 == ra2) && (ra2 != REG_XZR);
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed plus randomized bench for regfile_wr_arbiter against a rule-level reference model.
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_addr, req1_addr;
   logic [63:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic [4:0]  ra1, ra2;
   logic        byp1, byp2;
   logic [63:0] byp_data;
   logic        we3;
   logic [4:0]  wa3;
   logic [63:0] wd3;

   int tests = 0;
   int fails = 0;

   // reference model state
   int          m_last;
   logic        m_we;
   logic [4:0]  m_wa;
   logic [63:0] m_wd;
   int          last_g;
   logic [63:0] rf [32];

   always #5 clk = ~clk;

   regfile_wr_arbiter dut (
      .clk(clk), .reset(reset), .stall(stall),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .ra1(ra1), .ra2(ra2), .byp1(byp1), .byp2(byp2), .byp_data(byp_data),
      .we3(we3), .wa3(wa3), .wd3(wd3)
   );

   // behavioural regfile fed by the write port
   always @(posedge clk) if (we3) rf[wa3] <= wd3;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int exp_grant();
      if (!reset || stall) return -1;
      if (req0_valid && req1_valid) return 1 - m_last;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      m_last = 1;
      m_we   = 1'b0;
      m_wa   = 5'd0;
      m_wd   = 64'd0;
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic cycle();
      int g;
      #1;
      g = exp_grant();
      chk("ready0", req0_ready, g == 0);
      chk("ready1", req1_ready, g == 1);
      chk("byp1", byp1, m_we && m_wa == ra1 && ra1 != 5'd31);
      chk("byp2", byp2, m_we && m_wa == ra2 && ra2 != 5'd31);
      chk("byp_data", byp_data, m_wd);
      @(posedge clk);
      #1;
      if (!reset) model_reset();
      else if (g >= 0) begin
         m_last = g;
         m_wa   = (g == 1) ? req1_addr : req0_addr;
         m_wd   = (g == 1) ? req1_data : req0_data;
         m_we   = (m_wa != 5'd31);
      end else m_we = 1'b0;
      last_g = g;
      chk("we3", we3, m_we);
      chk("wa3", wa3, m_wa);
      chk("wd3", wd3, m_wd);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 64'd0;
      reset = 1'b0; stall = 1'b0;
      req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 64'd0;
      req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 64'd0;
      ra1 = 5'd0; ra2 = 5'd0; last_g = -1;
      model_reset();
      @(negedge clk);

      // reset: outputs clear, requests ignored
      chk("rst_we3", we3, 1'b0);
      chk("rst_wa3", wa3, 5'd0);
      chk("rst_wd3", wd3, 64'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      cycle();
      chk("rst_ready0", req0_ready, 1'b0);
      cycle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b1;
      cycle();

      // XZR write accepted and dropped
      req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 64'h55;
      #1 chk("xzr_ready1", req1_ready, 1'b1);
      cycle();
      chk("xzr_we3", we3, 1'b0);
      ra1 = 5'd31;
      #1 chk("xzr_byp1", byp1, 1'b0);

      // contention: req0 first, then alternating
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'h1111;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'h2222;
      for (int c = 0; c < 4; c++) begin
         cycle();
         chk("cont_wa3", wa3, (c % 2) ? 5'd2 : 5'd1);
      end

      // solo write with bypass, then visible in regfile
      req1_valid = 1'b0;
      req0_addr = 5'd5; req0_data = 64'hAA;
      cycle();
      req0_valid = 1'b0; ra1 = 5'd5;
      #1;
      chk("solo_byp1", byp1, 1'b1);
      chk("solo_byp_data", byp_data, 64'hAA);
      cycle();
      chk("solo_rf5", rf[5], 64'hAA);

      // stall blocks both, then order resumes from last (req0 was last)
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 64'h7;
      req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 64'h8;
      stall = 1'b1;
      for (int c = 0; c < 2; c++) begin
         cycle();
         chk("stall_we3", we3, 1'b0);
      end
      stall = 1'b0;
      cycle();
      chk("post_stall_wa3", wa3, 5'd8);

      // reset mid-operation discards the in-flight write
      req1_valid = 1'b0;
      req0_addr = 5'd3; req0_data = 64'h77;
      cycle();
      chk("mid_we3_before", we3, 1'b1);
      req0_valid = 1'b0;
      reset = 1'b0;
      #1;
      model_reset();
      chk("mid_we3_drop", we3, 1'b0);
      @(posedge clk);
      #1 chk("mid_rf3", rf[3], 64'd0);
      @(negedge clk);
      reset = 1'b1;
      cycle();

      // randomized traffic, requesters hold until granted
      for (int n = 0; n < 400; n++) begin
         if (!req0_valid || last_g == 0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_addr  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            req0_data  = {$urandom, $urandom};
         end
         if (!req1_valid || last_g == 1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_addr  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            req1_data  = {$urandom, $urandom};
         end
         stall = ($urandom_range(0, 7) == 0);
         ra1   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         ra2   = 5'($urandom_range(0, 7));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
